// File: rtl/pattern_rx.sv
// pattern_rx: decodes the single-wire NRZ LED stream back into a 5x5 on/off pattern and colour code.
// Optional build macro PATTERN_RX_ERRCHK_EN adds the high-time limit and short-frame rejection.
module pattern_rx #(
    parameter int T_THRESH     = 30,
    parameter int T_HIGH_MAX   = 60,
    parameter int RESET_CYCLES = 2500,
    parameter int NUM_PIXELS   = 25
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            data,
    output logic [4:0][4:0] pattern,
    output logic [2:0]      color,
    output logic            frame_valid,
    output logic            frame_err
);
    localparam int TW    = $clog2(RESET_CYCLES + T_HIGH_MAX + 2);
    localparam int NBITS = NUM_PIXELS * 24;
    localparam logic [TW-1:0] C_RESET  = TW'(RESET_CYCLES);
    localparam logic [TW-1:0] C_THRESH = TW'(T_THRESH);
    localparam logic [9:0]    C_NBITS  = 10'(NBITS);
`ifdef PATTERN_RX_ERRCHK_EN
    localparam logic [TW-1:0] C_HMAX   = TW'(T_HIGH_MAX);
`endif

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_d_meta;
    logic                  r_d_s;
    logic [TW-1:0]         r_timer;
    logic [9:0]            r_bit_cnt;
    logic [4:0]            r_bit_in_word;
    logic [4:0]            r_pix_idx;
    logic [22:0]           r_shift;
    logic [NUM_PIXELS-1:0] r_shadow;
    logic [2:0]            r_color_cand;
    logic [NUM_PIXELS-1:0] r_pattern;
    logic [2:0]            r_color;
    logic                  r_frame_valid;

    logic [TW-1:0]         w_timer_inc;
    logic                  w_low_done;
    logic                  w_bit_ev;
    logic                  w_bit_val;
    logic                  w_take;
    logic [23:0]           w_word;
    logic                  w_word_done;
    logic                  w_word_lit;
    logic                  w_clear;
    logic                  w_latch;
    logic                  w_any;
    logic                  w_commit;
    logic [NUM_PIXELS-1:0] w_shadow_set;
`ifdef PATTERN_RX_ERRCHK_EN
    logic                  r_err_pend;
    logic                  r_frame_err;
    logic                  w_full;
    logic                  w_hi_timeout;
    logic                  w_sync_exit;
    logic                  w_discard;
`endif

    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + TW'(1);
    assign w_low_done  = (r_timer >= C_RESET);

    // Two-flop synchronizer; all decoding uses r_d_s.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d_meta <= 1'b0;
            r_d_s    <= 1'b0;
        end else begin
            r_d_meta <= data;
            r_d_s    <= r_d_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_SYNC;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SYNC: if (!r_d_s && w_low_done) w_state_next = S_IDLE;
            S_IDLE: if (r_d_s) w_state_next = S_HIGH;
            S_HIGH: begin
                if (!r_d_s) w_state_next = S_LOW;
`ifdef PATTERN_RX_ERRCHK_EN
                else if (r_timer > C_HMAX) w_state_next = S_SYNC;
`endif
            end
            S_LOW: begin
                // The latch wins over a coincident rising edge; IDLE picks the edge up.
                if (w_low_done)  w_state_next = S_IDLE;
                else if (r_d_s)  w_state_next = S_HIGH;
            end
            default: w_state_next = S_SYNC;
        endcase
    end

    always_comb begin
        w_bit_ev    = (r_state == S_HIGH) && !r_d_s;
        w_bit_val   = (r_timer >= C_THRESH);
        w_take      = w_bit_ev && (r_bit_cnt < C_NBITS);
        w_word      = {r_shift, w_bit_val};
        w_word_done = w_take && (r_bit_in_word == 5'd23);
        w_word_lit  = (w_word != 24'd0);
        w_clear     = (r_state == S_SYNC) || (r_state == S_IDLE);
        w_latch     = (r_state == S_LOW) && w_low_done;
        w_any       = (r_bit_cnt != 10'd0);
`ifdef PATTERN_RX_ERRCHK_EN
        w_full       = (r_bit_cnt >= C_NBITS);
        w_hi_timeout = (r_state == S_HIGH) && r_d_s && (r_timer > C_HMAX);
        w_sync_exit  = (r_state == S_SYNC) && (w_state_next == S_IDLE);
        w_commit     = w_latch && w_full;
        w_discard    = (w_latch && w_any && !w_full) || (w_sync_exit && r_err_pend);
`else
        w_commit     = w_latch && w_any;
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
            assign w_shadow_set[gi] = w_word_done && w_word_lit && (r_pix_idx == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else begin
            case (r_state)
                S_SYNC:  r_timer <= (r_d_s || w_low_done) ? '0 : w_timer_inc;
                S_IDLE:  r_timer <= r_d_s ? TW'(1) : '0;
                S_HIGH:  r_timer <= !r_d_s ? TW'(1) : w_timer_inc;
                S_LOW: begin
                    if (w_low_done)  r_timer <= '0;
                    else if (r_d_s)  r_timer <= TW'(1);
                    else             r_timer <= w_timer_inc;
                end
                default: r_timer <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt     <= '0;
            r_bit_in_word <= '0;
            r_pix_idx     <= '0;
            r_shift       <= '0;
            r_shadow      <= '0;
            r_color_cand  <= '0;
        end else if (w_clear) begin
            r_bit_cnt     <= '0;
            r_bit_in_word <= '0;
            r_pix_idx     <= '0;
            r_shadow      <= '0;
            r_color_cand  <= '0;
        end else begin
            r_shadow <= r_shadow | w_shadow_set;
            if (w_take) begin
                r_bit_cnt <= r_bit_cnt + 10'd1;
                r_shift   <= w_word[22:0];
                if (w_word_done) begin
                    r_bit_in_word <= '0;
                    r_pix_idx     <= r_pix_idx + 5'd1;
                end else begin
                    r_bit_in_word <= r_bit_in_word + 5'd1;
                end
            end
            // Pixels arrive in index order, so the last lit word is the highest-index one.
            if (w_word_done && w_word_lit)
                r_color_cand <= {|w_word[15:8], |w_word[23:16], |w_word[7:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern     <= '0;
            r_color       <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_commit;
            if (w_commit) begin
                r_pattern <= r_shadow;
                r_color   <= r_color_cand;
            end
        end
    end

`ifdef PATTERN_RX_ERRCHK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_pend  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_discard;
            if (w_hi_timeout)     r_err_pend <= 1'b1;
            else if (w_sync_exit) r_err_pend <= 1'b0;
        end
    end
    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    assign pattern     = r_pattern;
    assign color       = r_color;
    assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_pattern_rx.sv
// Directed bench for pattern_rx with shortened timing parameters; expectations adapt to PATTERN_RX_ERRCHK_EN.
module tb_pattern_rx;
    localparam int P_THRESH = 4;
    localparam int P_HMAX   = 8;
    localparam int P_RESET  = 60;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            data = 1'b0;
    logic [4:0][4:0] pattern;
    logic [2:0]      color;
    logic            frame_valid;
    logic            frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_fv = 0;
    int n_fe = 0;
    int hi0 = 2;
    int hi1 = 6;
    int v0, e0;

    logic [23:0] frame_a [25];
    logic [23:0] frame_b [25];
    logic [24:0] exp_a, exp_b, exp_part;

    pattern_rx #(
        .T_THRESH    (P_THRESH),
        .T_HIGH_MAX  (P_HMAX),
        .RESET_CYCLES(P_RESET),
        .NUM_PIXELS  (25)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data       (data),
        .pattern    (pattern),
        .color      (color),
        .frame_valid(frame_valid),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) n_fv++;
        if (frame_err === 1'b1) n_fe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle_low(input int n);
        data = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        data = 1'b1;
        repeat (b ? hi1 : hi0) @(negedge clk);
        data = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // sel: 0 = frame A, 1 = frame B, 2 = all-zero words
    task automatic send_frame(input int sel, input int nbits);
        logic [23:0] w;
        for (int k = 0; k < nbits; k++) begin
            if (sel == 0)      w = frame_a[k / 24];
            else if (sel == 1) w = frame_b[k / 24];
            else               w = 24'd0;
            send_bit(w[23 - (k % 24)]);
        end
    endtask

    initial begin
        for (int k = 0; k < 25; k++) begin
            frame_a[k] = 24'd0;
            frame_b[k] = 24'd0;
        end
        // Rows {10101,00100,00100,00100,10101} -> pixels 0,2,4,7,12,17,20,22,24
        foreach (frame_a[k]) if (k inside {0, 2, 4, 7, 12, 17, 20, 22, 24}) frame_a[k] = 24'h00FF00;
        exp_a    = 25'b1_0101_0010_0001_0000_1001_0101;
        frame_b[3]  = 24'hFF0000;
        frame_b[20] = 24'h00FF01;
        exp_b    = 25'd0;
        exp_b[3] = 1'b1;
        exp_b[20] = 1'b1;
        exp_part = 25'b0_0000_0000_0000_0000_1001_0101;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pattern", {7'd0, pattern}, 32'd0);
        check("rst_color", {29'd0, color}, 32'd0);
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);

        reset_n = 1'b1;
        idle_low(100);
        check("idle_pattern", {7'd0, pattern}, 32'd0);
        check("idle_color", {29'd0, color}, 32'd0);
        check("idle_pulses", n_fv + n_fe, 32'd0);

        hi0 = 2; hi1 = 6; v0 = n_fv; e0 = n_fe;
        send_frame(0, 600); idle_low(100);
        check("a_valid", n_fv - v0, 1);
        check("a_err", n_fe - e0, 0);
        check("a_pattern", {7'd0, pattern}, {7'd0, exp_a});
        check("a_color", {29'd0, color}, 32'd4);

        hi0 = 1; hi1 = P_HMAX; v0 = n_fv; e0 = n_fe;
        send_frame(1, 600); idle_low(100);
        check("b_valid", n_fv - v0, 1);
        check("b_err", n_fe - e0, 0);
        check("b_pattern", {7'd0, pattern}, {7'd0, exp_b});
        check("b_color", {29'd0, color}, 32'd5);

        hi0 = 2; hi1 = 6; v0 = n_fv;
        send_frame(2, 600); idle_low(100);
        check("z_valid", n_fv - v0, 1);
        check("z_pattern", {7'd0, pattern}, 32'd0);
        check("z_color", {29'd0, color}, 32'd0);

        send_frame(0, 600); idle_low(100);
        check("a2_pattern", {7'd0, pattern}, {7'd0, exp_a});

        v0 = n_fv; e0 = n_fe;
        send_frame(0, 300); idle_low(100);
`ifdef PATTERN_RX_ERRCHK_EN
        check("p_err", n_fe - e0, 1);
        check("p_valid", n_fv - v0, 0);
        check("p_pattern", {7'd0, pattern}, {7'd0, exp_a});
`else
        check("p_valid", n_fv - v0, 1);
        check("p_err", n_fe - e0, 0);
        check("p_pattern", {7'd0, pattern}, {7'd0, exp_part});
`endif
        check("p_color", {29'd0, color}, 32'd4);

        hi0 = P_THRESH - 1; hi1 = P_THRESH; v0 = n_fv; e0 = n_fe;
        send_frame(1, 600);
        for (int i = 0; i < 100; i++) send_bit(1'b1);
        idle_low(100);
        check("long_valid", n_fv - v0, 1);
        check("long_err", n_fe - e0, 0);
        check("long_pattern", {7'd0, pattern}, {7'd0, exp_b});
        check("long_color", {29'd0, color}, 32'd5);

        hi0 = 2; hi1 = 6; v0 = n_fv; e0 = n_fe;
        send_frame(0, 240);
        reset_n = 1'b0;
        #1;
        check("mr_pattern", {7'd0, pattern}, 32'd0);
        check("mr_color", {29'd0, color}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle_low(100);
        check("mr_pulses", (n_fv - v0) + (n_fe - e0), 0);
        check("mr_hold", {7'd0, pattern}, 32'd0);

        v0 = n_fv; e0 = n_fe;
        data = 1'b1;
        repeat (12) @(negedge clk);
        idle_low(100);
`ifdef PATTERN_RX_ERRCHK_EN
        check("hi_err", n_fe - e0, 1);
        check("hi_valid", n_fv - v0, 0);
`else
        check("hi_valid", n_fv - v0, 1);
        check("hi_err", n_fe - e0, 0);
`endif
        check("hi_pattern", {7'd0, pattern}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
